// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared helpers for the gray decode arbiter
// Purpose: requester-index width helper and a reference gray-to-binary
//          function (wide enough for any WIDTH up to 32; narrower codes are
//          zero-extended, which leaves the low result bits unchanged).
package gray_pkg;

    localparam int GRAY_MAX_W = 32;

    // Index width for n requesters; never narrower than one bit.
    function automatic int calc_id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Binary bit k is the XOR of gray bits MSB..k.
    function automatic logic [GRAY_MAX_W-1:0] gray_to_bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b = '0;
        for (int k = 0; k < GRAY_MAX_W; k++) begin
            b[k] = ^(g >> k);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_to_binary.sv
// rtl/gray_to_binary.sv - combinational gray code to binary decoder
// Purpose: decodes one WIDTH-bit gray word.
// Ports:   gray   - gray-coded input
//          binary - decoded binary output
module gray_to_binary #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] binary
);

    always_comb begin
        binary = '0;
        for (int k = 0; k < WIDTH; k++) begin
            binary[k] = ^(gray >> k);
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant search with rotating priority pointer
// Purpose: picks the first asserted request at or after rr_ptr (wrapping at
//          NUM_REQ-1) and moves the pointer past the winner on advance.
// Ports:   clk, reset  - clock, synchronous active-high reset
//          req         - request vector
//          advance     - grant was consumed this cycle
//          grant_idx   - index of the winning request
//          grant_valid - at least one request asserted
module rr_arbiter import gray_pkg::*; #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = calc_id_w(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_valid
);

    logic [ID_W-1:0] rr_ptr_q;
    logic [ID_W-1:0] rr_ptr_d;

    // Scan offsets from farthest to nearest so the nearest asserted request
    // (lowest offset from rr_ptr) is the one left standing.
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            int idx;
            idx = int'(rr_ptr_q) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[idx]) begin
                grant_idx   = ID_W'(idx);
                grant_valid = 1'b1;
            end
        end
    end

    // Explicit wrap keeps the pointer below NUM_REQ for non-power-of-two counts.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (advance) begin
            rr_ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/gray_decode_arbiter.sv
// rtl/gray_decode_arbiter.sv - round-robin sharing of one gray decoder
// Purpose: NUM_REQ requesters offer gray codes; the granted one is decoded
//          and returned with its index through a registered valid/ready stage.
// Ports:   clk, reset            - clock, synchronous active-high reset
//          req_valid/req_ready   - per-requester handshake (ready one-hot or 0)
//          req_gray              - packed gray codes, requester i at [i*WIDTH +: WIDTH]
//          out_valid/out_ready   - result handshake
//          out_binary, out_id    - decoded value and producing requester
module gray_decode_arbiter import gray_pkg::*; #(
    parameter  int WIDTH   = 4,
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = calc_id_w(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_gray,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_binary,
    output logic [ID_W-1:0]          out_id
);

    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_binary_q, out_binary_d;
    logic [ID_W-1:0]   out_id_q, out_id_d;

    logic [ID_W-1:0]   grant_idx;
    logic              grant_valid;
    logic              free;
    logic              xfer;
    logic [WIDTH-1:0]  gray_sel;
    logic [WIDTH-1:0]  dec_binary;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req         (req_valid),
        .advance     (xfer),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    gray_to_binary #(
        .WIDTH (WIDTH)
    ) u_dec (
        .gray   (gray_sel),
        .binary (dec_binary)
    );

    // out_ready reaches req_ready combinationally so a draining output can be
    // refilled in the same cycle; the output register itself only sees it
    // through the flop enables.
    always_comb begin
        free      = !out_valid_q || out_ready;
        xfer      = grant_valid && free && !reset;
        req_ready = xfer ? (NUM_REQ'(1) << grant_idx) : '0;
        gray_sel  = req_gray[int'(grant_idx)*WIDTH +: WIDTH];
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_binary_d = out_binary_q;
        out_id_d     = out_id_q;
        if (xfer) begin
            out_valid_d  = 1'b1;
            out_binary_d = dec_binary;
            out_id_d     = grant_idx;
        end else if (out_ready) begin
            out_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_binary_q <= '0;
            out_id_q     <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_binary_q <= out_binary_d;
            out_id_q     <= out_id_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_binary = out_binary_q;
    assign out_id     = out_id_q;

endmodule

// File: tb/tb_gray_decode_arbiter.sv
// tb/tb_gray_decode_arbiter.sv - directed self-checking bench for gray_decode_arbiter
module tb_gray_decode_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_gray;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_binary;
    logic [1:0]  out_id;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gray_decode_arbiter #(
        .WIDTH   (4),
        .NUM_REQ (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_gray   (req_gray),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_binary (out_binary),
        .out_id     (out_id)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] ref_g2b(input logic [3:0] g);
        return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    endfunction

    task automatic check_out(input string tag, input logic v, input logic [3:0] b, input logic [1:0] id);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".binary"}, 32'(out_binary), 32'(b));
        check({tag, ".id"}, 32'(out_id), 32'(id));
    endtask

    logic [1:0] rr_ids  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] rr_bins [5] = '{4'b0001, 4'b0011, 4'b0111, 4'b1010, 4'b0001};

    initial begin
        reset     = 1'b1;
        req_valid = 4'b1111;
        req_gray  = '0;
        out_ready = 1'b1;
        #1;
        check("rst.ready_held_low", 32'(req_ready), 32'h0);
        tick();
        tick();
        req_valid = 4'b0000;
        reset     = 1'b0;

        // idle after reset
        for (int i = 0; i < 5; i++) begin
            #1;
            check_out("idle", 1'b0, 4'b0000, 2'd0);
            check("idle.ready", 32'(req_ready), 32'h0);
            tick();
        end

        // single transfer from requester 2
        req_gray[8 +: 4] = 4'b1000;
        req_valid        = 4'b0100;
        #1;
        check("single.ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'b0000;
        check_out("single.out", 1'b1, 4'b1111, 2'd2);
        tick();
        check_out("single.drain", 1'b0, 4'b1111, 2'd2);

        // reset to bring the pointer back to 0, then round-robin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_gray  = {4'b1111, 4'b0100, 4'b0010, 4'b0001};
        req_valid = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rr.ready", 32'(req_ready), 32'(4'b0001 << rr_ids[k]));
            tick();
            check_out("rr.out", 1'b1, rr_bins[k], rr_ids[k]);
        end

        // produce id1 result, then stall
        tick();
        check_out("bp.pending", 1'b1, 4'b0011, 2'd1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp.ready", 32'(req_ready), 32'h0);
            check("bp.rr_ptr", 32'(dut.u_arb.rr_ptr_q), 32'd2);
            tick();
            check_out("bp.hold", 1'b1, 4'b0011, 2'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp.release_ready", 32'(req_ready), 32'b0100);
        tick();
        check_out("bp.next", 1'b1, 4'b0111, 2'd2);

        // reset while a result is stalled
        out_ready = 1'b0;
        reset     = 1'b1;
        #1;
        check("rstmid.ready", 32'(req_ready), 32'h0);
        tick();
        check_out("rstmid.cleared", 1'b0, 4'b0000, 2'd0);
        reset     = 1'b0;
        out_ready = 1'b1;
        req_valid = 4'b1001;
        #1;
        check("rstmid.ready0", 32'(req_ready), 32'b0001);
        tick();
        check_out("rstmid.first", 1'b1, 4'b0001, 2'd0);
        check("rstmid.ready3", 32'(req_ready), 32'b1000);
        tick();
        check_out("rstmid.second", 1'b1, 4'b1010, 2'd3);

        // exhaustive decode through requester 1
        req_valid = 4'b0010;
        for (int g = 0; g < 16; g++) begin
            req_gray[4 +: 4] = 4'(g);
            #1;
            check("exh.ready", 32'(req_ready), 32'b0010);
            tick();
            check_out("exh.out", 1'b1, ref_g2b(4'(g)), 2'd1);
            if (g == 13) begin
                check("exh.1101", 32'(out_binary), 32'b1001);
            end
        end
        req_valid = 4'b0000;
        tick();
        check("exh.drain", 32'(out_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
